// File: rtl/bit_add_4_pkg.sv
// rtl/bit_add_4_pkg.sv - shared constants for the bit_add_4 adder leaf
package bit_add_4_pkg;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/bit_add_4_full_adder.sv
// rtl/bit_add_4_full_adder.sv - one-bit full adder, the ripple-chain cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/bit_add_4.sv
// rtl/bit_add_4.sv - ripple-carry adder with combinational sum and registered sum/carry/overflow
module bit_add_4
    import bit_add_4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] out,
    output logic             co,
    output logic [WIDTH-1:0] out_q,
    output logic             co_q,
    output logic             ovf_q
);

    logic [WIDTH:0] c;
    logic           ovf;

    assign c[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (out[i]),
            .co (c[i+1])
        );
    end

    assign co = c[WIDTH];
    // Carry into and out of the sign bit disagree exactly when the signed result overflows.
    assign ovf = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out;
            co_q  <= co;
            ovf_q <= ovf;
        end
    end

endmodule

// File: tb/tb_bit_add_4.sv
// tb/tb_bit_add_4.sv - self-checking bench for bit_add_4 against an arithmetic reference model
module tb_bit_add_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a, b;
    logic       ci;
    logic [3:0] out, out_q;
    logic       co, co_q, ovf_q;

    int errors = 0;
    int checks = 0;

    bit_add_4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .out   (out),
        .co    (co),
        .out_q (out_q),
        .co_q  (co_q),
        .ovf_q (ovf_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum at 5 bits and signed range test on two's-complement values.
    function automatic logic [4:0] ref_sum(input logic [3:0] x, input logic [3:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[4:0];
    endfunction

    function automatic logic ref_ovf(input logic [3:0] x, input logic [3:0] y, input logic c);
        int sx, sy, s;
        sx = x[3] ? int'(x) - 16 : int'(x);
        sy = y[3] ? int'(y) - 16 : int'(y);
        s  = sx + sy + int'(c);
        return (s > 7) || (s < -8);
    endfunction

    task automatic apply(input logic [3:0] x, input logic [3:0] y, input logic c, input string tag);
        logic [4:0] e;
        e = ref_sum(x, y, c);
        @(negedge clk);
        a = x; b = y; ci = c;
        #1;
        check({tag, ".out"}, {4'h0, out}, {4'h0, e[3:0]});
        check({tag, ".co"},  {7'h0, co},  {7'h0, e[4]});
        @(posedge clk);
        #1;
        check({tag, ".out_q"}, {4'h0, out_q}, {4'h0, e[3:0]});
        check({tag, ".co_q"},  {7'h0, co_q},  {7'h0, e[4]});
        check({tag, ".ovf_q"}, {7'h0, ovf_q}, {7'h0, ref_ovf(x, y, c)});
    endtask

    initial begin
        rst_n = 1'b0; a = 4'h0; b = 4'h0; ci = 1'b0;
        @(posedge clk);
        #1;
        check("rst.out_q", {4'h0, out_q}, 8'h00);
        check("rst.co_q",  {7'h0, co_q},  8'h00);
        check("rst.ovf_q", {7'h0, ovf_q}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        apply(4'b0000, 4'b0000, 1'b0, "zero");
        apply(4'b0001, 4'b0001, 1'b0, "one_one");
        apply(4'b0001, 4'b0001, 1'b1, "one_one_ci");
        apply(4'b1111, 4'b1111, 1'b1, "ff_ci");
        apply(4'b1111, 4'b0000, 1'b1, "f0_ci");
        apply(4'b1000, 4'b1000, 1'b0, "neg_ovf");
        apply(4'b0111, 4'b0001, 1'b0, "pos_ovf");

        // Registers hold nonzero data here; reset must clear them while out/co keep tracking.
        @(negedge clk);
        rst_n = 1'b0; a = 4'b1111; b = 4'b0001; ci = 1'b0;
        #1;
        check("rsthold.out", {4'h0, out}, 8'h00);
        check("rsthold.co",  {7'h0, co},  8'h01);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rsthold.out_q", {4'h0, out_q}, 8'h00);
            check("rsthold.co_q",  {7'h0, co_q},  8'h00);
            check("rsthold.ovf_q", {7'h0, ovf_q}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstrel.out_q", {4'h0, out_q}, 8'h00);
        check("rstrel.co_q",  {7'h0, co_q},  8'h01);
        check("rstrel.ovf_q", {7'h0, ovf_q}, 8'h00);

        for (int v = 0; v < 512; v++) begin
            logic [8:0] vv;
            vv = v[8:0];
            apply(vv[3:0], vv[7:4], vv[8], "sweep");
        end

        for (int n = 0; n < 100; n++) begin
            logic [31:0] r;
            r = $urandom;
            apply(r[3:0], r[7:4], r[8], "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
